// File: rtl/decode_stage_pkg.sv
// Shared decode constants: MIPS opcode/funct encodings, memory access widths, control word layout.
// Every user of the control word imports this package so the bit positions stay in one place.
package decode_stage_pkg;

    localparam logic [5:0] EXE_SPECIAL = 6'h00;
    localparam logic [5:0] EXE_REGIMM  = 6'h01;
    localparam logic [5:0] EXE_J       = 6'h02;
    localparam logic [5:0] EXE_BEQ     = 6'h04;
    localparam logic [5:0] EXE_BNE     = 6'h05;
    localparam logic [5:0] EXE_BLEZ    = 6'h06;
    localparam logic [5:0] EXE_BGTZ    = 6'h07;
    localparam logic [5:0] EXE_ADDI    = 6'h08;
    localparam logic [5:0] EXE_ADDIU   = 6'h09;
    localparam logic [5:0] EXE_SLTI    = 6'h0A;
    localparam logic [5:0] EXE_SLTIU   = 6'h0B;
    localparam logic [5:0] EXE_ANDI    = 6'h0C;
    localparam logic [5:0] EXE_ORI     = 6'h0D;
    localparam logic [5:0] EXE_XORI    = 6'h0E;
    localparam logic [5:0] EXE_LUI     = 6'h0F;
    localparam logic [5:0] EXE_LB      = 6'h20;
    localparam logic [5:0] EXE_LH      = 6'h21;
    localparam logic [5:0] EXE_LW      = 6'h23;
    localparam logic [5:0] EXE_LBU     = 6'h24;
    localparam logic [5:0] EXE_LHU     = 6'h25;
    localparam logic [5:0] EXE_SB      = 6'h28;
    localparam logic [5:0] EXE_SH      = 6'h29;
    localparam logic [5:0] EXE_SW      = 6'h2B;

    localparam logic [4:0] EXE_BLTZ    = 5'h00;
    localparam logic [4:0] EXE_BGEZ    = 5'h01;

    localparam logic [5:0] EXE_SLL     = 6'h00;
    localparam logic [5:0] EXE_SRL     = 6'h02;
    localparam logic [5:0] EXE_SRA     = 6'h03;
    localparam logic [5:0] EXE_SLLV    = 6'h04;
    localparam logic [5:0] EXE_SRLV    = 6'h06;
    localparam logic [5:0] EXE_SRAV    = 6'h07;
    localparam logic [5:0] EXE_MFHI    = 6'h10;
    localparam logic [5:0] EXE_MTHI    = 6'h11;
    localparam logic [5:0] EXE_MFLO    = 6'h12;
    localparam logic [5:0] EXE_MTLO    = 6'h13;
    localparam logic [5:0] EXE_MULT    = 6'h18;
    localparam logic [5:0] EXE_MULTU   = 6'h19;
    localparam logic [5:0] EXE_DIV     = 6'h1A;
    localparam logic [5:0] EXE_DIVU    = 6'h1B;
    localparam logic [5:0] EXE_ADD     = 6'h20;
    localparam logic [5:0] EXE_ADDU    = 6'h21;
    localparam logic [5:0] EXE_SUB     = 6'h22;
    localparam logic [5:0] EXE_SUBU    = 6'h23;
    localparam logic [5:0] EXE_AND     = 6'h24;
    localparam logic [5:0] EXE_OR      = 6'h25;
    localparam logic [5:0] EXE_XOR     = 6'h26;
    localparam logic [5:0] EXE_NOR     = 6'h27;
    localparam logic [5:0] EXE_SLT     = 6'h2A;
    localparam logic [5:0] EXE_SLTU    = 6'h2B;

    // WORD is zero so non-memory instructions carry a clean all-zero field
    localparam logic [1:0] MEM_WORD     = 2'b00;
    localparam logic [1:0] MEM_BYTE     = 2'b01;
    localparam logic [1:0] MEM_HALFWORD = 2'b10;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic       regdst;
        logic       regwrite;
        logic       jump;
        logic       hilowrite;
        logic       memsignext;
        logic [1:0] membyte;
        logic       illegal;
        logic       muldiv;
        logic       hiloread;
    } ctrl_t;

    function automatic ctrl_t illegal_ctrl();
        ctrl_t c;
        c         = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_maindec.sv
// Combinational main decoder: opcode/rt/funct to control word, zero latency, no flow control.
// Disabled instruction groups decode exactly like unknown opcodes.
module maindec_v2
    import decode_stage_pkg::*;
#(
    parameter int ENABLE_MULDIV  = 1,
    parameter int ENABLE_SUBWORD = 1
) (
    input  logic [5:0] i_op,
    input  logic [4:0] i_rt,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_op)
            EXE_SPECIAL: begin
                o_ctrl.regdst   = 1'b1;
                o_ctrl.regwrite = 1'b1;
                case (i_funct)
                    EXE_SLL, EXE_SRL, EXE_SRA, EXE_SLLV, EXE_SRLV, EXE_SRAV,
                    EXE_ADD, EXE_ADDU, EXE_SUB, EXE_SUBU, EXE_AND, EXE_OR,
                    EXE_XOR, EXE_NOR, EXE_SLT, EXE_SLTU: ;
                    EXE_MFHI, EXE_MFLO: begin
                        if (ENABLE_MULDIV != 0) o_ctrl.hiloread = 1'b1;
                        else                    o_ctrl = illegal_ctrl();
                    end
                    EXE_MTHI, EXE_MTLO: begin
                        if (ENABLE_MULDIV != 0) begin
                            o_ctrl.regwrite  = 1'b0;
                            o_ctrl.hilowrite = 1'b1;
                        end else begin
                            o_ctrl = illegal_ctrl();
                        end
                    end
                    EXE_MULT, EXE_MULTU, EXE_DIV, EXE_DIVU: begin
                        if (ENABLE_MULDIV != 0) begin
                            o_ctrl.regwrite  = 1'b0;
                            o_ctrl.hilowrite = 1'b1;
                            o_ctrl.muldiv    = 1'b1;
                        end else begin
                            o_ctrl = illegal_ctrl();
                        end
                    end
                    default: o_ctrl = illegal_ctrl();
                endcase
            end
            EXE_REGIMM: begin
                if (i_rt == EXE_BLTZ || i_rt == EXE_BGEZ) o_ctrl.branch = 1'b1;
                else                                      o_ctrl = illegal_ctrl();
            end
            EXE_J:                                   o_ctrl.jump = 1'b1;
            EXE_BEQ, EXE_BNE, EXE_BLEZ, EXE_BGTZ:    o_ctrl.branch = 1'b1;
            EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU,
            EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI: begin
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            EXE_LW: begin
                o_ctrl.memtoreg   = 1'b1;
                o_ctrl.alusrc     = 1'b1;
                o_ctrl.regwrite   = 1'b1;
                o_ctrl.memsignext = 1'b1;
                o_ctrl.membyte    = MEM_WORD;
            end
            EXE_LB, EXE_LH, EXE_LBU, EXE_LHU: begin
                if (ENABLE_SUBWORD != 0) begin
                    o_ctrl.memtoreg   = 1'b1;
                    o_ctrl.alusrc     = 1'b1;
                    o_ctrl.regwrite   = 1'b1;
                    o_ctrl.memsignext = (i_op == EXE_LB) || (i_op == EXE_LH);
                    o_ctrl.membyte    = (i_op == EXE_LB || i_op == EXE_LBU) ? MEM_BYTE : MEM_HALFWORD;
                end else begin
                    o_ctrl = illegal_ctrl();
                end
            end
            EXE_SW: begin
                o_ctrl.memwrite = 1'b1;
                o_ctrl.alusrc   = 1'b1;
                o_ctrl.membyte  = MEM_WORD;
            end
            EXE_SB, EXE_SH: begin
                if (ENABLE_SUBWORD != 0) begin
                    o_ctrl.memwrite = 1'b1;
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.membyte  = (i_op == EXE_SB) ? MEM_BYTE : MEM_HALFWORD;
                end else begin
                    o_ctrl = illegal_ctrl();
                end
            end
            default: o_ctrl = illegal_ctrl();
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry output register, 1-cycle latency, full throughput with valid/ready.
// Stalls upstream while downstream is full, on flush, or while a HI/LO user meets a busy mul/div.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int ENABLE_MULDIV  = 1,
    parameter int ENABLE_SUBWORD = 1,
    parameter int MUL_CYCLES     = 4,
    parameter int DIV_CYCLES     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] out_ctrl,
    output logic [31:0] out_inst,
    output logic        hilo_busy
);

    ctrl_t       w_dec;
    logic        w_hilo_stall;
    logic        w_accept;
    logic        w_is_div;
    logic [5:0]  w_busy_load;

    logic        r_out_valid;
    ctrl_t       r_ctrl;
    logic [31:0] r_inst;
    logic [5:0]  r_busy_cnt;

    maindec_v2 #(
        .ENABLE_MULDIV  (ENABLE_MULDIV),
        .ENABLE_SUBWORD (ENABLE_SUBWORD)
    ) u_maindec (
        .i_op    (inst[31:26]),
        .i_rt    (inst[20:16]),
        .i_funct (inst[5:0]),
        .o_ctrl  (w_dec)
    );

    assign hilo_busy    = (r_busy_cnt != 6'd0);
    assign w_hilo_stall = hilo_busy && (w_dec.hiloread || w_dec.hilowrite || w_dec.muldiv);
    assign in_ready     = (!r_out_valid || out_ready) && !w_hilo_stall && !flush;
    assign w_accept     = in_valid && in_ready;
    assign w_is_div     = (inst[5:0] == EXE_DIV) || (inst[5:0] == EXE_DIVU);
    assign w_busy_load  = w_is_div ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
            r_inst      <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_ctrl      <= w_dec;
            r_inst      <= inst;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A load can only happen with the counter at zero: a busy counter stalls every muldiv
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= 6'd0;
        end else if (w_accept && w_dec.muldiv) begin
            r_busy_cnt <= w_busy_load;
        end else if (r_busy_cnt != 6'd0) begin
            r_busy_cnt <= r_busy_cnt - 6'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ctrl  = r_ctrl;
    assign out_inst  = r_inst;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, HI/LO interlock timing, backpressure, flush, reset.
// A second instance with mul/div and sub-word support disabled covers the illegal paths.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready, hilo_busy;
    logic [31:0] inst, out_inst;
    logic [13:0] out_ctrl;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_hilo_busy;
    logic [31:0] b_inst, b_out_inst;
    logic [13:0] b_out_ctrl;

    int n_vec = 0;
    int n_err = 0;

    // {memtoreg,memwrite,branch,alusrc,regdst,regwrite,jump,hilowrite,memsignext,membyte[1:0],illegal,muldiv,hiloread}
    localparam logic [13:0] C_LW     = 14'b1_0_0_1_0_1_0_0_1_00_0_0_0;
    localparam logic [13:0] C_SB     = 14'b0_1_0_1_0_0_0_0_0_01_0_0_0;
    localparam logic [13:0] C_LHU    = 14'b1_0_0_1_0_1_0_0_0_10_0_0_0;
    localparam logic [13:0] C_BR     = 14'b0_0_1_0_0_0_0_0_0_00_0_0_0;
    localparam logic [13:0] C_J      = 14'b0_0_0_0_0_0_1_0_0_00_0_0_0;
    localparam logic [13:0] C_IALU   = 14'b0_0_0_1_0_1_0_0_0_00_0_0_0;
    localparam logic [13:0] C_RALU   = 14'b0_0_0_0_1_1_0_0_0_00_0_0_0;
    localparam logic [13:0] C_ILL    = 14'b0_0_0_0_0_0_0_0_0_00_1_0_0;
    localparam logic [13:0] C_MTLO   = 14'b0_0_0_0_1_0_0_1_0_00_0_0_0;
    localparam logic [13:0] C_MULDIV = 14'b0_0_0_0_1_0_0_1_0_00_0_1_0;
    localparam logic [13:0] C_MFHILO = 14'b0_0_0_0_1_1_0_0_0_00_0_0_1;

    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_DIV  = 32'h0085001A;
    localparam logic [31:0] I_MULT = 32'h00850018;
    localparam logic [31:0] I_MFLO = 32'h00001012;
    localparam logic [31:0] I_MFHI = 32'h00001010;
    localparam logic [31:0] I_ADDU = 32'h00851021;
    localparam logic [31:0] I_ADDI = 32'h20820000;
    localparam logic [31:0] I_LB   = 32'h80220000;

    decode_stage u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_inst  (out_inst),
        .hilo_busy (hilo_busy)
    );

    decode_stage #(
        .ENABLE_MULDIV  (0),
        .ENABLE_SUBWORD (0)
    ) u_dut_min (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .inst      (b_inst),
        .flush     (b_flush),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_ctrl  (b_out_ctrl),
        .out_inst  (b_out_inst),
        .hilo_busy (b_hilo_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic ordy, input logic fl);
        in_valid  = v;
        inst      = i;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] tv_inst [10];
    logic [13:0] tv_ctrl [10];
    int          waited;

    initial begin
        tv_inst[0] = 32'hA0220000; tv_ctrl[0] = C_SB;
        tv_inst[1] = 32'h94220000; tv_ctrl[1] = C_LHU;
        tv_inst[2] = 32'h10220003; tv_ctrl[2] = C_BR;
        tv_inst[3] = 32'h04800002; tv_ctrl[3] = C_BR;
        tv_inst[4] = 32'h08000010; tv_ctrl[4] = C_J;
        tv_inst[5] = 32'h20820001; tv_ctrl[5] = C_IALU;
        tv_inst[6] = I_ADDU;       tv_ctrl[6] = C_RALU;
        tv_inst[7] = 32'hFC000000; tv_ctrl[7] = C_ILL;
        tv_inst[8] = 32'h00000008; tv_ctrl[8] = C_ILL;
        tv_inst[9] = 32'h00800013; tv_ctrl[9] = C_MTLO;

        rst = 1'b1;
        b_in_valid = 1'b0; b_inst = '0; b_out_ready = 1'b1; b_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset out_ctrl", out_ctrl, 0);
        chk("reset out_inst", out_inst, 0);
        chk("reset hilo_busy", hilo_busy, 0);
        rst = 1'b0;
        #1;

        // Disabled sub-word and mul/div decode as illegal
        b_in_valid = 1'b1; b_inst = I_LB;
        tick();
        chk("nosub LB ctrl", b_out_ctrl, C_ILL);
        chk("nosub LB illegal", b_out_ctrl[2], 1);
        chk("nosub LB regwrite", b_out_ctrl[8], 0);
        chk("nosub LB memtoreg", b_out_ctrl[13], 0);
        b_inst = I_MULT;
        tick();
        chk("nomd MULT ctrl", b_out_ctrl, C_ILL);
        chk("nomd MULT busy", b_hilo_busy, 0);
        b_inst = I_LW;
        tick();
        chk("nosub LW ctrl", b_out_ctrl, C_LW);
        b_in_valid = 1'b0;

        drive(1'b1, I_LW, 1'b1, 1'b0);
        chk("LW in_ready", in_ready, 1);
        tick();
        chk("LW out_valid", out_valid, 1);
        chk("LW out_ctrl", out_ctrl, C_LW);
        chk("LW out_inst", out_inst, I_LW);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tv_inst[i], 1'b1, 1'b0);
            tick();
            chk($sformatf("table[%0d] ctrl", i), out_ctrl, tv_ctrl[i]);
            chk($sformatf("table[%0d] inst", i), out_inst, tv_inst[i]);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("idle out_valid", out_valid, 0);

        // MULT then MFHI: interlock lasts MUL_CYCLES
        drive(1'b1, I_MULT, 1'b1, 1'b0);
        tick();
        chk("MULT ctrl", out_ctrl, C_MULDIV);
        chk("MULT busy", hilo_busy, 1);
        drive(1'b1, I_MFHI, 1'b1, 1'b0);
        waited = 0;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        chk("MFHI stall cycles", waited, 4);
        tick();
        chk("MFHI ctrl", out_ctrl, C_MFHILO);
        chk("MFHI inst", out_inst, I_MFHI);

        // DIV then MFLO back to back
        drive(1'b1, I_DIV, 1'b1, 1'b0);
        tick();
        chk("DIV ctrl", out_ctrl, C_MULDIV);
        chk("DIV hilowrite", out_ctrl[6], 1);
        drive(1'b1, I_MFLO, 1'b1, 1'b0);
        waited = 0;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        chk("MFLO stall cycles", waited, 32);
        tick();
        chk("MFLO out_valid", out_valid, 1);
        chk("MFLO ctrl", out_ctrl, C_MFHILO);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        // Downstream backpressure holds the entry, then full-rate stream
        drive(1'b1, I_ADDU, 1'b0, 1'b0);
        tick();
        chk("hold first valid", out_valid, 1);
        drive(1'b1, I_ADDI | 32'd1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold[%0d] in_ready", i), in_ready, 0);
            tick();
            chk($sformatf("hold[%0d] inst", i), out_inst, I_ADDU);
            chk($sformatf("hold[%0d] ctrl", i), out_ctrl, C_RALU);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, I_ADDI | 32'(i), 1'b1, 1'b0);
            chk($sformatf("stream[%0d] in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("stream[%0d] inst", i), out_inst, I_ADDI | 32'(i));
            chk($sformatf("stream[%0d] valid", i), out_valid, 1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        // Flush drops the held and incoming entries but leaves the counter running
        drive(1'b1, I_MULT, 1'b0, 1'b0);
        tick();
        chk("pre-flush valid", out_valid, 1);
        drive(1'b1, I_ADDU, 1'b0, 1'b1);
        chk("flush in_ready", in_ready, 0);
        tick();
        chk("flush out_valid", out_valid, 0);
        chk("flush hilo_busy", hilo_busy, 1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("post-flush dropped", out_valid, 0);
        waited = 0;
        while (hilo_busy && waited < 200) begin
            tick();
            waited++;
        end
        chk("flush busy drained", waited, 2);

        // Reset while busy=17 with the output held
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (15) tick();
        chk("pre-rst busy", hilo_busy, 1);
        chk("pre-rst valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async rst busy", hilo_busy, 0);
        chk("async rst valid", out_valid, 0);
        chk("async rst ctrl", out_ctrl, 0);
        in_valid  = 1'b1;
        inst      = I_MFHI;
        out_ready = 1'b1;
        rst       = 1'b0;
        #1;
        chk("post-rst in_ready", in_ready, 1);
        tick();
        chk("post-rst MFHI valid", out_valid, 1);
        chk("post-rst MFHI ctrl", out_ctrl, C_MFHILO);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter ENABLE_MULDIV, default 1, meaning: decode MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO; when 0 these SHALL flag illegal.
REQ-002 Parameter ENABLE_SUBWORD, default 1, meaning: decode LB/LBU/LH/LHU/SB/SH; when 0 these SHALL flag illegal.
REQ-003 Parameter MUL_CYCLES, default 4, meaning: HI/LO busy cycles after MULT/MULTU issue (range 1..63).
REQ-004 Parameter DIV_CYCLES, default 32, meaning: HI/LO busy cycles after DIV/DIVU issue (range 1..63).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 in_valid  in  1 / in_ready  out  1 / inst  in  32: upstream instruction handshake.
REQ-008 flush  in  1: discard held and incoming instruction this cycle.
REQ-009 out_valid  out  1 / out_ready  in  1: downstream handshake.
REQ-010 out_ctrl  out  14: {memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, hilowrite, memsignext, membyte[1:0], illegal, muldiv, hiloread}.
REQ-011 out_inst  out  32: instruction associated with out_ctrl.
REQ-012 hilo_busy  out  1: HI/LO busy counter non-zero.

Function
REQ-013 Decode SHALL match the team's single-cycle main decoder for all supported opcodes (loads memtoreg=1; stores memwrite=1; BEQ/BNE/BGEZ/BGTZ/BLEZ/BLTZ branch=1; I-type ALU and memory alusrc=1; R-type regdst=1; J jump=1; LBU/LHU memsignext=0; membyte BYTE/HALFWORD/WORD).
REQ-014 R-type regwrite SHALL be 0 for MULT/MULTU/DIV/DIVU/MTHI/MTLO; hilowrite=1 for those six.
REQ-015 Unsupported or parameter-disabled opcode/funct SHALL give illegal=1 with regwrite, memwrite, branch, jump, hilowrite all 0.
REQ-016 muldiv=1 for MULT/MULTU/DIV/DIVU; hiloread=1 for MFHI/MFLO.
REQ-017 Output register: one-entry; transfer on in_valid && in_ready; latency inst-to-out_valid exactly 1 cycle.
REQ-018 in_ready = (!out_valid || out_ready) && !hilo_stall && !flush.
REQ-019 hilo_stall = hilo_busy && incoming decode has hiloread, hilowrite or muldiv.
REQ-020 out_valid/out_ctrl/out_inst SHALL hold stable while out_valid && !out_ready.
REQ-021 Busy counter loads MUL_CYCLES or DIV_CYCLES when a muldiv instruction transfers into the output register; otherwise decrements by 1 per cycle while non-zero; never wraps below 0.
REQ-022 Load and decrement same cycle cannot occur (stall rule); counter width 6 bits.
REQ-023 flush SHALL clear out_valid next cycle and block acceptance that cycle; busy counter SHALL NOT be cleared by flush.
REQ-024 Simultaneous out_ready and new accept: old entry leaves, new entry loads same edge (full throughput, no bubble).

Reset
REQ-025 rst asserted asynchronously: out_valid=0, out_ctrl=0, out_inst=0, busy counter=0, hilo_busy=0.
REQ-026 rst mid-operation (busy or output stalled) SHALL abandon all state; first accept possible first cycle after rst deasserts.

Structure
REQ-027 Opcode/funct constants (EXE_*), MEM_BYTE/MEM_HALFWORD/MEM_WORD and out_ctrl bit positions SHALL live in shared defines.vh.
REQ-028 Combinational decode SHALL be a sub-module maindec_v2 (parameters ENABLE_MULDIV, ENABLE_SUBWORD); decode_stage holds register, handshake and counter.

Verification
REQ-029 LW 0x8C220004 valid, out_ready=1 -> next cycle out_valid=1, memtoreg=1, alusrc=1, regwrite=1, membyte=WORD, illegal=0.
REQ-030 DIV 0x0085001A then MFLO 0x00001012 back-to-back, DIV_CYCLES=32 -> MFLO in_ready=0 for 32 cycles, accepted cycle 33, hilowrite=1 on DIV.
REQ-031 ENABLE_SUBWORD=0, LB 0x80220000 -> illegal=1, regwrite=0, memtoreg=0.
REQ-032 out_ready=0 for 5 cycles holding ADDU -> out_ctrl/out_inst unchanged, in_ready=0; out_ready=1 -> stream of 4 ADDI at one per cycle.
REQ-033 flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming dropped, hilo_busy unchanged.
REQ-034 rst pulse during busy=17 -> hilo_busy=0 immediately, MFHI accepted first cycle after release.
